// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clkgen_div multi-channel clock divider.
package clkgen_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } chan_state_e;

    // Divisors below DIV_MIN cannot form a high and a low phase, so they are raised.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: run/drain state machine, period counter, active and pending divisor.
// Tick output only exists when CLKGEN_TICK_EN is defined; otherwise it is tied low.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             div_clk,
    output logic             tick,
    output logic             busy
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             div_clk_q, div_clk_d;
    logic             busy_q, busy_d;
    logic             wrap;
    logic             apply;

    assign wrap = (cnt_q == div_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        apply      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                apply = pend_q;
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                apply = pend_q && wrap;
                if (!run) begin
                    state_d = wrap ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                apply = pend_q && wrap;
                if (run) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new divisor only lands at a period boundary, so no period mixes two divisors.
        if (apply) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
        end
        if (wr_en) begin
            pend_d     = 1'b1;
            pend_div_d = DIV_W'(clamp_div(32'(wr_div)));
        end

        busy_d    = (state_d != ST_IDLE);
        div_clk_d = busy_d && (cnt_d < (div_d >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= RESET_DIV;
            pend_div_q <= RESET_DIV;
            pend_q     <= 1'b0;
            div_clk_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            div_clk_q  <= div_clk_d;
            busy_q     <= busy_d;
        end
    end

`ifdef CLKGEN_TICK_EN
    logic tick_q, tick_d;

    always_comb begin
        tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

    assign pend    = pend_q;
    assign div_clk = div_clk_q;
    assign busy    = busy_q;

endmodule

// File: rtl/clkgen_div.sv
// Multi-channel programmable clock divider top: cfg write decode and cfg_ready mux.
// Define CLKGEN_TICK_EN to build the per-period tick outputs.
module clkgen_div
    import clkgen_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] run,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy
);

    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wr_en;

    // Out-of-range channel indices are never accepted.
    assign cfg_ready = (32'(cfg_ch) < CHANNELS) ? !pend[cfg_ch] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign wr_en[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

            clkgen_chan #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .run     (run[gi]),
                .wr_en   (wr_en[gi]),
                .wr_div  (cfg_div),
                .pend    (pend[gi]),
                .div_clk (div_clk[gi]),
                .tick    (tick[gi]),
                .busy    (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clkgen_div.sv
// Directed self-checking bench for clkgen_div (4 channels, 8-bit divisors, default divisor 2).
module tb_clkgen_div;

`ifdef CLKGEN_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] run = '0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_ready;
    logic [3:0] div_clk;
    logic [3:0] tick;
    logic [3:0] busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clkgen_div #(
        .CHANNELS    (4),
        .DIV_W       (8),
        .DEFAULT_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write a divisor to an idle channel: accept edge, then the copy edge.
    task automatic write_idle(input logic [1:0] ch, input logic [7:0] dv);
        cfg_ch = ch; cfg_div = dv; cfg_valid = 1'b1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL write_ready ch%0d got=%b exp=1", ch, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        step();
        $display("cfg write ch=%0d div=%0d ready_after=%b", ch, dv, cfg_ready);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({div_clk, tick, busy} !== 12'h000) begin
            failures++; $display("FAIL reset_outputs got=%h exp=000", {div_clk, tick, busy});
        end
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                failures++; $display("FAIL reset_ready ch%0d got=%b exp=1", c, cfg_ready);
            end
        end
        $display("reset released outputs=%h", {div_clk, tick, busy});
    endtask

    task automatic test_default_div();
        logic [5:0] e = 6'b101010;
        run[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (div_clk[0] !== e[5-i] || tick[0] !== (e[5-i] & TICK_EN) || busy[0] !== 1'b1) begin
                failures++;
                $display("FAIL default_div i=%0d clk/tick/busy got=%b%b%b exp=%b%b1",
                         i, div_clk[0], tick[0], busy[0], e[5-i], e[5-i] & TICK_EN);
            end
        end
        run[0] = 1'b0;
        step();
        checks++;
        if (busy[0] !== 1'b0 || div_clk[0] !== 1'b0) begin
            failures++; $display("FAIL default_stop busy/clk got=%b%b exp=00", busy[0], div_clk[0]);
        end
        $display("default_div ch0 done");
    endtask

    task automatic test_odd_div();
        logic [9:0] ec = 10'b1100011000;
        logic [9:0] et = 10'b1000010000;
        write_idle(2'd1, 8'd5);
        run[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (div_clk[1] !== ec[9-i] || tick[1] !== (et[9-i] & TICK_EN)) begin
                failures++;
                $display("FAIL odd_div i=%0d clk/tick got=%b%b exp=%b%b",
                         i, div_clk[1], tick[1], ec[9-i], et[9-i] & TICK_EN);
            end
        end
        run[1] = 1'b0;
        step();
        checks++;
        if (busy[1] !== 1'b0) begin
            failures++; $display("FAIL odd_stop busy got=%b exp=0", busy[1]);
        end
        $display("odd_div ch1 D=5 done");
    endtask

    task automatic test_update_running();
        logic [8:0] ec = 9'b001110001;
        logic [8:0] et = 9'b001000001;
        logic [8:0] er = 9'b001111111;
        logic [5:0] sb = 6'b111110;
        logic [5:0] sc = 6'b110000;
        write_idle(2'd0, 8'd4);
        run[0] = 1'b1;
        step(); step();
        cfg_ch = 2'd0; cfg_div = 8'd6; cfg_valid = 1'b1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL update_ready_pre got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        $display("cfg write ch=0 div=6 at cnt=1");
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            checks++;
            if (div_clk[0] !== ec[8-i] || tick[0] !== (et[8-i] & TICK_EN) || cfg_ready !== er[8-i]) begin
                failures++;
                $display("FAIL update_run i=%0d clk/tick/ready got=%b%b%b exp=%b%b%b", i,
                         div_clk[0], tick[0], cfg_ready, ec[8-i], et[8-i] & TICK_EN, er[8-i]);
            end
        end
        run[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (busy[0] !== sb[5-i] || div_clk[0] !== sc[5-i] || tick[0] !== 1'b0) begin
                failures++;
                $display("FAIL update_drain i=%0d busy/clk/tick got=%b%b%b exp=%b%b0",
                         i, busy[0], div_clk[0], tick[0], sb[5-i], sc[5-i]);
            end
        end
    endtask

    task automatic test_drain_stop();
        logic [5:0] sb = 6'b111110;
        logic [5:0] sc = 6'b100000;
        write_idle(2'd2, 8'd8);
        run[2] = 1'b1;
        step();
        checks++;
        if (div_clk[2] !== 1'b1 || tick[2] !== TICK_EN) begin
            failures++; $display("FAIL drain_start clk/tick got=%b%b exp=1%b", div_clk[2], tick[2], TICK_EN);
        end
        step(); step();
        run[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (busy[2] !== sb[5-i] || div_clk[2] !== sc[5-i] || tick[2] !== 1'b0) begin
                failures++;
                $display("FAIL drain_stop i=%0d busy/clk/tick got=%b%b%b exp=%b%b0",
                         i, busy[2], div_clk[2], tick[2], sb[5-i], sc[5-i]);
            end
        end
        $display("drain_stop ch2 D=8 done");
    endtask

    task automatic test_clamp_refuse();
        logic [5:0] e = 6'b101010;
        cfg_ch = 2'd3; cfg_div = 8'd0; cfg_valid = 1'b1;
        step();
        cfg_div = 8'd7;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++; $display("FAIL refuse_ready got=%b exp=0", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL refuse_ready_back got=%b exp=1", cfg_ready);
        end
        $display("cfg write ch=3 div=0 accepted, div=7 refused");
        run[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (div_clk[3] !== e[5-i] || tick[3] !== (e[5-i] & TICK_EN)) begin
                failures++;
                $display("FAIL clamp0 i=%0d clk/tick got=%b%b exp=%b%b",
                         i, div_clk[3], tick[3], e[5-i], e[5-i] & TICK_EN);
            end
        end
        run[3] = 1'b0;
        step();
        write_idle(2'd3, 8'd1);
        run[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (div_clk[3] !== e[5-i]) begin
                failures++; $display("FAIL clamp1 i=%0d clk got=%b exp=%b", i, div_clk[3], e[5-i]);
            end
        end
        run[3] = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        write_idle(2'd2, 8'd4);
        run[2] = 1'b1;
        step(); step();
        run[2] = 1'b0;
        step();
        checks++;
        if ({busy[2], div_clk[2], tick[2]} !== 3'b100) begin
            failures++; $display("FAIL b2b_drain got=%b exp=100", {busy[2], div_clk[2], tick[2]});
        end
        run[2] = 1'b1;
        step();
        checks++;
        if ({busy[2], div_clk[2], tick[2]} !== 3'b100) begin
            failures++; $display("FAIL b2b_resume got=%b exp=100", {busy[2], div_clk[2], tick[2]});
        end
        step();
        checks++;
        if ({busy[2], div_clk[2], tick[2]} !== {2'b11, TICK_EN}) begin
            failures++; $display("FAIL b2b_wrap got=%b exp=11%b", {busy[2], div_clk[2], tick[2]}, TICK_EN);
        end
        step();
        checks++;
        if ({busy[2], div_clk[2], tick[2]} !== 3'b110) begin
            failures++; $display("FAIL b2b_cnt1 got=%b exp=110", {busy[2], div_clk[2], tick[2]});
        end
        $display("back_to_back ch2 drain->run done");
    endtask

    task automatic test_reset_mid();
        logic [3:0] e = 4'b1010;
        run = 4'hF;
        step();
        cfg_ch = 2'd0; cfg_div = 8'd9; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        checks++;
        if (busy !== 4'hF) begin
            failures++; $display("FAIL mid_busy got=%h exp=f", busy);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({div_clk, tick, busy} !== 12'h000) begin
            failures++; $display("FAIL mid_reset_outputs got=%h exp=000", {div_clk, tick, busy});
        end
        run = 4'h0;
        rst_n = 1'b1;
        step();
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset_ready ch0 got=%b exp=1", cfg_ready);
        end
        run = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (div_clk[1:0] !== {e[3-i], e[3-i]} || tick[1:0] !== {2{e[3-i] & TICK_EN}}) begin
                failures++;
                $display("FAIL mid_restart i=%0d clk=%b tick=%b exp_clk=%b%b", i,
                         div_clk[1:0], tick[1:0], e[3-i], e[3-i]);
            end
        end
        run = 4'h0;
        $display("reset_mid restart at D=2 done");
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_odd_div();
        test_update_running();
        test_drain_stop();
        test_clamp_refuse();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
